pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-PC controller for the 5-stage pipelined CPU. It owns the program-counter register and sequences it through start-up, sequential fetch, stalls, taken branches (resolved in EX), jumps (resolved in ID) and halt. It also drives the flush strobes for the IF/ID and ID/EX pipeline registers. It sits in the IF stage, and its `pc` output addresses instruction memory directly.

## Interface
- `N`, default 16: datapath width. The PC width is `N-3` (13 bits at default).
- `RESET_VEC`, default 0: first fetch address after start from IDLE.
- `clk` input 1: clock. Rising-edge active.
- `reset` input 1: one clock; reset is asynchronous and active-low.
- `start` input 1: begins fetching from IDLE, or resumes from HALT.
- `stall` input 1: load-use hold request from hazard unit.
- `halt` input 1: decoded halt instruction in ID.
- `branch_taken` input 1: taken branch resolved in EX.
- `branch_target` input N-3: target of the EX branch.
- `jump` input 1: jump decoded in ID.
- `jump_target` input N-3: target of the ID jump.
- `pc` output N-3: registered fetch address.
- `pc_valid` output 1: registered. Marks that `pc` is a real fetch this cycle.
- `flush_ifid` output 1: combinational. Squashes the IF/ID register at the next edge.
- `flush_idex` output 1: combinational. Squashes the ID/EX register at the next edge.
- `running` output 1: registered. High in RUN.

## Operation
- Three states, 2-bit encoding: IDLE=0, RUN=1, HALT=2. Encoding 3 is illegal and recovers to IDLE at the next edge.
- Reset (`reset`=0, asynchronous):
  - state=IDLE, `pc`=RESET_VEC, `pc_valid`=0, `running`=0.
  - Flush outputs are 0 while in reset.
- IDLE:
  - `pc` holds, `pc_valid`=0.
  - `start`=1 → RUN, `pc`<=RESET_VEC, `pc_valid`<=1.
  - All other inputs are ignored.
- RUN, next-PC priority (highest first):
  1. `branch_taken` → `pc`<=`branch_target`. `flush_ifid`=1 and `flush_idex`=1. `jump`, `halt` and `stall` are ignored that cycle, because they come from the wrong path.
  2. `jump` → `pc`<=`jump_target`. `flush_ifid`=1 and `flush_idex`=0. `stall` is ignored.
  3. `halt` → HALT. `pc` holds, `pc_valid`<=0, `flush_ifid`=1.
  4. `stall` → `pc` holds, `pc_valid` stays 1, no flush.
  5. Otherwise → `pc`<=`pc`+1 (word addressed).
- PC arithmetic:
  - Modulo 2^(N-3). All-ones +1 wraps to 0 with no flag.
  - Targets are used unmodified.
- `jump` and `halt` together in RUN: the jump wins. This case is illegal from decode but must be deterministic.
- HALT:
  - `pc` holds the address after the halt instruction, `pc_valid`=0.
  - `start`=1 → RUN, `pc_valid`<=1, fetching resumes at the held `pc` with no increment.
  - `branch_taken`, `jump`, `stall` and `halt` are ignored.
- Flush outputs are 0 outside RUN.
- `start` in RUN is ignored.

## Timing
- All state, `pc`, `pc_valid` and `running` update on the `clk` rising edge. Reset is the only asynchronous path.
- Flush outputs are combinational from the RUN state and the inputs. They are consumed at the same edge that loads the redirect target.
- Start latency: `start` sampled high at edge k → `pc`=RESET_VEC and `pc_valid`=1 after edge k.
- Redirect latency: a target sampled at edge k appears on `pc` after edge k, so there is zero bubble in IF.
- Branch penalty is 2 squashed instructions. Jump penalty is 1.
- Stall: `pc` is unchanged after each edge where `stall`=1. Sequential fetch resumes the cycle `stall` drops.
- Reset asserted mid-run:
  - Outputs reach their reset values immediately, without waiting for `clk`.
  - After release, the block stays in IDLE until `start`.
- Reset release is synchronised to `clk` by the integrator. The block needs no internal synchroniser.

## Test plan
- Reset then start:
  - Stimulus: deassert `reset`, pulse `start` for 1 cycle, RESET_VEC=0.
  - Required: `pc` goes 0,1,2,3 on consecutive cycles. `pc_valid`=1 from the first edge. `running`=1.
- Branch vs stall/jump:
  - Stimulus: at `pc`=5, assert `branch_taken`=1 with `branch_target`=0x040, together with `stall`=1 and `jump`=1 (`jump_target`=0x100).
  - Required: `pc`=0x040 next. `flush_ifid`=`flush_idex`=1 for that cycle. The next cycle `pc`=0x041.
- Jump plus stall:
  - Stimulus: at `pc`=9, assert `jump`=1 with `jump_target`=0x1F0, and `stall`=1.
  - Required: `pc`=0x1F0. `flush_ifid`=1, `flush_idex`=0.
- Stall hold and wrap:
  - Stimulus: run to `pc`=0x1FFE, then hold `stall` for 3 cycles.
  - Required: `pc` stays 0x1FFE for 3 cycles, then goes 0x1FFF, then 0x0000.
- Halt and resume:
  - Stimulus: `halt` at `pc`=12.
  - Required:
    - `pc` holds 12, `pc_valid`=0, `flush_ifid` pulses once.
    - An asserted `branch_taken` is ignored while halted.
    - `start` resumes with `pc`=12, then 13.
- Asynchronous reset mid-run:
  - Stimulus: drop `reset` between clock edges while `pc`=0x023.
  - Required:
    - `pc`=0, `pc_valid`=0 and `running`=0 immediately.
    - After release with no `start`, `pc` stays 0 for 10 cycles.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-control bundle between the pipeline control logic and the next-PC sequencer
interface pc_sequencer_if #(
   parameter int N = 16
);
   localparam int PW = N - 3;

   logic          start;
   logic          stall;
   logic          halt;
   logic          branch_taken;
   logic [PW-1:0] branch_target;
   logic          jump;
   logic [PW-1:0] jump_target;
   logic [PW-1:0] pc;
   logic          pc_valid;
   logic          flush_ifid;
   logic          flush_idex;
   logic          running;

   modport master (
      output start, stall, halt, branch_taken, branch_target, jump, jump_target,
      input  pc, pc_valid, flush_ifid, flush_idex, running
   );

   modport slave (
      input  start, stall, halt, branch_taken, branch_target, jump, jump_target,
      output pc, pc_valid, flush_ifid, flush_idex, running
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC controller: owns the PC and sequences start, fetch, stall, redirect and halt
module pc_sequencer #(
   parameter int N         = 16,
   parameter int RESET_VEC = 0
) (
   input  logic           clk,
   input  logic           reset,
   pc_sequencer_if.slave  bus
);
   localparam int PW = N - 3;
   localparam logic [PW-1:0] RESET_PC = PW'(RESET_VEC);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pc_q, pc_d;
   logic          pc_valid_q, pc_valid_d;
   logic          running_q, running_d;
   logic          flush_ifid, flush_idex;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_valid_d = pc_valid_q;
      running_d  = running_q;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      case (state_q)
         S_IDLE: begin
            pc_valid_d = 1'b0;
            running_d  = 1'b0;
            if (bus.start) begin
               state_d    = S_RUN;
               pc_d       = RESET_PC;
               pc_valid_d = 1'b1;
               running_d  = 1'b1;
            end
         end
         S_RUN: begin
            pc_valid_d = 1'b1;
            running_d  = 1'b1;
            // EX branch outranks everything younger: ID jump/halt and stall are wrong-path
            if (bus.branch_taken) begin
               pc_d       = bus.branch_target;
               flush_ifid = 1'b1;
               flush_idex = 1'b1;
            end else if (bus.jump) begin
               pc_d       = bus.jump_target;
               flush_ifid = 1'b1;
            end else if (bus.halt) begin
               state_d    = S_HALT;
               pc_valid_d = 1'b0;
               running_d  = 1'b0;
               flush_ifid = 1'b1;
            end else if (!bus.stall) begin
               pc_d = pc_q + PW'(1);
            end
         end
         S_HALT: begin
            pc_valid_d = 1'b0;
            running_d  = 1'b0;
            // resume at the held PC, which already points past the halt instruction
            if (bus.start) begin
               state_d    = S_RUN;
               pc_valid_d = 1'b1;
               running_d  = 1'b1;
            end
         end
         default: begin
            state_d    = S_IDLE;
            pc_valid_d = 1'b0;
            running_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         pc_valid_q <= 1'b0;
         running_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         running_q  <= running_d;
      end
   end

   assign bus.pc         = pc_q;
   assign bus.pc_valid   = pc_valid_q;
   assign bus.running    = running_q;
   assign bus.flush_ifid = flush_ifid;
   assign bus.flush_idex = flush_idex;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed-vector bench for pc_sequencer
module tb_pc_sequencer;
   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   pc_sequencer_if #(.N(16)) bus ();

   pc_sequencer #(.N(16), .RESET_VEC(0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.start         = 1'b0;
      bus.stall         = 1'b0;
      bus.halt          = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      bus.jump          = 1'b0;
      bus.jump_target   = '0;
   endtask

   task automatic branch_to(input logic [12:0] tgt);
      bus.branch_taken  = 1'b1;
      bus.branch_target = tgt;
      step();
      clear_inputs();
   endtask

   task automatic check_flush(input string tag, input logic ifid, input logic idex);
      #1;
      check_vec({tag, "_flush_ifid"}, {31'd0, bus.flush_ifid}, {31'd0, ifid});
      check_vec({tag, "_flush_idex"}, {31'd0, bus.flush_idex}, {31'd0, idex});
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      clear_inputs();
      bus.branch_taken = 1'b1;
      bus.jump         = 1'b1;
      @(negedge clk);
      check_vec("rst_pc", {19'd0, bus.pc}, 32'h0);
      check_vec("rst_valid", {31'd0, bus.pc_valid}, 32'd0);
      check_vec("rst_running", {31'd0, bus.running}, 32'd0);
      check_flush("rst", 1'b0, 1'b0);
      clear_inputs();
      reset = 1'b1;
      step();
      check_vec("idle_valid", {31'd0, bus.pc_valid}, 32'd0);

      // start: pc 0,1,2,3
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check_vec("start_pc0", {19'd0, bus.pc}, 32'h0);
      check_vec("start_valid", {31'd0, bus.pc_valid}, 32'd1);
      check_vec("start_running", {31'd0, bus.running}, 32'd1);
      for (int i = 1; i <= 5; i++) begin
         step();
         check_vec("seq_pc", {19'd0, bus.pc}, i);
      end

      // branch at pc=5 beats stall and jump
      bus.branch_taken  = 1'b1;
      bus.branch_target = 13'h040;
      bus.stall         = 1'b1;
      bus.jump          = 1'b1;
      bus.jump_target   = 13'h100;
      check_flush("br", 1'b1, 1'b1);
      step();
      clear_inputs();
      check_vec("br_pc", {19'd0, bus.pc}, 32'h040);
      check_flush("br_after", 1'b0, 1'b0);
      step();
      check_vec("br_next", {19'd0, bus.pc}, 32'h041);

      // jump at pc=9 beats stall
      branch_to(13'd9);
      check_vec("to9", {19'd0, bus.pc}, 32'd9);
      bus.jump        = 1'b1;
      bus.jump_target = 13'h1F0;
      bus.stall       = 1'b1;
      check_flush("jmp", 1'b1, 1'b0);
      step();
      clear_inputs();
      check_vec("jmp_pc", {19'd0, bus.pc}, 32'h1F0);
      check_vec("jmp_valid", {31'd0, bus.pc_valid}, 32'd1);

      // jump and halt together: jump wins, stays running
      bus.jump        = 1'b1;
      bus.jump_target = 13'h1FFE;
      bus.halt        = 1'b1;
      check_flush("jh", 1'b1, 1'b0);
      step();
      clear_inputs();
      check_vec("jh_pc", {19'd0, bus.pc}, 32'h1FFE);
      check_vec("jh_running", {31'd0, bus.running}, 32'd1);

      // stall hold then wrap
      bus.stall = 1'b1;
      check_flush("stall", 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_vec("stall_pc", {19'd0, bus.pc}, 32'h1FFE);
         check_vec("stall_valid", {31'd0, bus.pc_valid}, 32'd1);
      end
      bus.stall = 1'b0;
      step();
      check_vec("wrap_1fff", {19'd0, bus.pc}, 32'h1FFF);
      step();
      check_vec("wrap_0", {19'd0, bus.pc}, 32'h0000);

      // halt at pc=12
      branch_to(13'd12);
      check_vec("to12", {19'd0, bus.pc}, 32'd12);
      bus.halt = 1'b1;
      check_flush("halt", 1'b1, 1'b0);
      step();
      check_vec("halt_pc", {19'd0, bus.pc}, 32'd12);
      check_vec("halt_valid", {31'd0, bus.pc_valid}, 32'd0);
      check_vec("halt_running", {31'd0, bus.running}, 32'd0);
      check_flush("halted", 1'b0, 1'b0);
      bus.halt          = 1'b0;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 13'h055;
      bus.jump          = 1'b1;
      bus.jump_target   = 13'h0AA;
      check_flush("halt_br", 1'b0, 1'b0);
      step();
      clear_inputs();
      check_vec("halt_br_pc", {19'd0, bus.pc}, 32'd12);
      check_vec("halt_br_valid", {31'd0, bus.pc_valid}, 32'd0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check_vec("resume_pc", {19'd0, bus.pc}, 32'd12);
      check_vec("resume_valid", {31'd0, bus.pc_valid}, 32'd1);
      check_vec("resume_running", {31'd0, bus.running}, 32'd1);
      step();
      check_vec("resume_next", {19'd0, bus.pc}, 32'd13);

      // start while running is ignored
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check_vec("start_in_run", {19'd0, bus.pc}, 32'd14);

      // asynchronous reset mid-run
      branch_to(13'h023);
      check_vec("to23", {19'd0, bus.pc}, 32'h023);
      #2;
      reset = 1'b0;
      #1;
      check_vec("arst_pc", {19'd0, bus.pc}, 32'h0);
      check_vec("arst_valid", {31'd0, bus.pc_valid}, 32'd0);
      check_vec("arst_running", {31'd0, bus.running}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check_vec("post_rst_pc", {19'd0, bus.pc}, 32'h0);
         check_vec("post_rst_valid", {31'd0, bus.pc_valid}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
